pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the stall and flush inputs of the F/D, D/E and E/M pipeline registers from four sources: I-fetch wait, D-mem wait, multi-cycle EX busy, and load-use hazards.
- Sequences EX-stage control-flow redirects. A redirect that arrives while an I-fetch is outstanding drains the stale response before the PC is redirected.

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, including redirect draining.
// Optional perf counters are enabled with PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int PC_W  = 64,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ifetch_req,
  input  logic             iresp_data_ok,
  input  logic             dmem_wait,
  input  logic             exe_busy,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic [PC_W-1:0]  ex_redirect_pc,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             drop_iresp,
  output logic             busy
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_freeze_cyc,
  output logic [31:0]      perf_lu_stall,
  output logic [31:0]      perf_redirects
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] redirect_pc_reg;
  logic            freeze, iwait, lu;
  logic            accept, lu_stall;

  assign freeze = dmem_wait | exe_busy;
  assign iwait  = ifetch_req & ~iresp_data_ok;
  assign lu     = ex_is_load & (ex_rd != '0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      redirect_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) redirect_pc_reg <= ex_redirect_pc;
    end
  end

  always_comb begin
    state_next     = state_reg;
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    stall_e        = 1'b0;
    stall_m        = 1'b0;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    redirect_valid = 1'b0;
    drop_iresp     = 1'b0;
    busy           = 1'b0;
    accept         = 1'b0;
    lu_stall       = 1'b0;
    if (reset) begin
      flush_d    = 1'b1;
      flush_e    = 1'b1;
      state_next = IDLE;
    end else begin
      busy = (state_reg != IDLE);
      if (freeze) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        // The stale response can still arrive while the back-end is frozen.
        if (state_reg == DRAIN) begin
          drop_iresp = 1'b1;
          if (iresp_data_ok) state_next = REDIR;
        end
      end else begin
        unique case (state_reg)
          IDLE: begin
            if (ex_redirect) begin
              flush_d    = 1'b1;
              flush_e    = 1'b1;
              stall_f    = 1'b1;
              accept     = 1'b1;
              state_next = iwait ? DRAIN : REDIR;
            end else if (lu) begin
              stall_f  = 1'b1;
              stall_d  = 1'b1;
              flush_e  = 1'b1;
              lu_stall = 1'b1;
            end else if (iwait) begin
              stall_f = 1'b1;
              flush_d = 1'b1;
            end
          end
          DRAIN: begin
            stall_f    = 1'b1;
            flush_d    = 1'b1;
            drop_iresp = 1'b1;
            if (iresp_data_ok) state_next = REDIR;
          end
          REDIR: begin
            redirect_valid = 1'b1;
            flush_d        = 1'b1;
            state_next     = IDLE;
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  assign redirect_pc = reset ? '0 : redirect_pc_reg;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_freeze_cyc <= '0;
      perf_lu_stall   <= '0;
      perf_redirects  <= '0;
    end else begin
      if (freeze)   perf_freeze_cyc <= perf_freeze_cyc + 32'd1;
      if (lu_stall) perf_lu_stall   <= perf_lu_stall + 32'd1;
      if (accept)   perf_redirects  <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random stimulus
// compared against a pending-redirect reference model.
module tb_pipe_hazard_ctrl;
  localparam int PC_W  = 64;
  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             ifetch_req, iresp_data_ok, dmem_wait, exe_busy;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
  logic [PC_W-1:0]  ex_redirect_pc;
  logic             stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic             redirect_valid, drop_iresp, busy;
  logic [PC_W-1:0]  redirect_pc;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0]      perf_freeze_cyc, perf_lu_stall, perf_redirects;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: a redirect is either absent, pending behind a stale fetch, or ready.
  bit              m_pending, m_draining;
  logic [PC_W-1:0] m_pc;
  int unsigned     m_freeze_cnt, m_lu_cnt, m_redir_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.PC_W(PC_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset),
    .ifetch_req(ifetch_req), .iresp_data_ok(iresp_data_ok),
    .dmem_wait(dmem_wait), .exe_busy(exe_busy),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .drop_iresp(drop_iresp), .busy(busy)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .perf_freeze_cyc(perf_freeze_cyc), .perf_lu_stall(perf_lu_stall),
    .perf_redirects(perf_redirects)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit model_lu();
    return ex_is_load && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  task automatic clear_inputs();
    reset = 0; ifetch_req = 0; iresp_data_ok = 0; dmem_wait = 0; exe_busy = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_is_load = 0; ex_rd = 0; ex_redirect = 0; ex_redirect_pc = 0;
  endtask

  // Called at a negedge with inputs applied; checks outputs, then advances the model.
  task automatic step();
    bit sf, sd, se, sm, fd, fe, rv, dr, bz;
    bit frz, iw;
    logic [8:0] exp_vec, obs_vec;
    #1;
    frz = dmem_wait || exe_busy;
    iw  = ifetch_req && !iresp_data_ok;
    {sf, sd, se, sm, fd, fe, rv, dr, bz} = '0;
    if (reset) begin
      fd = 1; fe = 1;
    end else begin
      bz = m_pending;
      if (frz) begin
        {sf, sd, se, sm} = 4'b1111;
        dr = m_pending && m_draining;
      end else if (m_pending && m_draining) begin
        sf = 1; fd = 1; dr = 1;
      end else if (m_pending) begin
        rv = 1; fd = 1;
      end else if (ex_redirect) begin
        fd = 1; fe = 1; sf = 1;
      end else if (model_lu()) begin
        sf = 1; sd = 1; fe = 1;
      end else if (iw) begin
        sf = 1; fd = 1;
      end
    end
    exp_vec = {sf, sd, se, sm, fd, fe, rv, dr, bz};
    obs_vec = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, redirect_valid, drop_iresp, busy};
    check("ctl", 64'(obs_vec), 64'(exp_vec));
    check("rpc", redirect_pc, reset ? 64'd0 : m_pc);
    @(posedge clk);
    if (reset) begin
      m_pending = 0; m_draining = 0; m_pc = 0;
      m_freeze_cnt = 0; m_lu_cnt = 0; m_redir_cnt = 0;
    end else begin
      if (frz) m_freeze_cnt++;
      if (m_pending && m_draining) begin
        if (iresp_data_ok) m_draining = 0;
      end else if (m_pending) begin
        if (!frz) m_pending = 0;
      end else if (!frz && ex_redirect) begin
        m_pending = 1; m_draining = iw; m_pc = ex_redirect_pc; m_redir_cnt++;
      end else if (!frz && model_lu()) begin
        m_lu_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_perf();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    #1;
    check("perf_freeze", 64'(perf_freeze_cyc), 64'(m_freeze_cnt));
    check("perf_lu", 64'(perf_lu_stall), 64'(m_lu_cnt));
    check("perf_redir", 64'(perf_redirects), 64'(m_redir_cnt));
`endif
  endtask

  initial begin
    clear_inputs();
    m_pending = 0; m_draining = 0; m_pc = 0;
    m_freeze_cnt = 0; m_lu_cnt = 0; m_redir_cnt = 0;
    @(negedge clk);
    reset = 1;
    repeat (3) step();
    #1 check("rst_flush", 64'({flush_d, flush_e, busy}), 64'b110);
    reset = 0;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // Three plain redirects and seven frozen cycles.
    for (int r = 0; r < 3; r++) begin
      ex_redirect = 1; ex_redirect_pc = 64'h1000 + 64'(r);
      step();
      ex_redirect = 0;
      repeat (2) step();
    end
    exe_busy = 1;
    repeat (7) step();
    exe_busy = 0;
    #1;
    check("perf_redir3", 64'(perf_redirects), 64'd3);
    check("perf_frz7", 64'(perf_freeze_cyc), 64'd7);
`endif

    // Load-use hit, then ex_rd=0 which never hazards.
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1 check("lu_hit", 64'({stall_f, stall_d, flush_e}), 64'b111);
    step();
    ex_rd = 0; id_rs1 = 0;
    #1 check("lu_x0", 64'({stall_f, stall_d, flush_e}), 64'b000);
    step();
    clear_inputs();

    // Redirect with no fetch outstanding.
    ex_redirect = 1; ex_redirect_pc = 64'h8000_0040;
    step();
    ex_redirect = 0;
    #1 check("redir_t1", 64'({redirect_valid, flush_d}), 64'b11);
    check("redir_pc", redirect_pc, 64'h8000_0040);
    step();
    #1 check("redir_t2_idle", 64'(busy), 64'd0);
    step();

    // Redirect while a fetch is outstanding; response at t+3.
    ifetch_req = 1; iresp_data_ok = 0; ex_redirect = 1; ex_redirect_pc = 64'h8000_1000;
    step();
    ex_redirect = 0;
    repeat (2) begin
      #1 check("drain_drop", 64'(drop_iresp), 64'd1);
      step();
    end
    iresp_data_ok = 1;
    step();
    ifetch_req = 0; iresp_data_ok = 0;
    #1 check("drain_rv", 64'({redirect_valid, drop_iresp}), 64'b10);
    step();

    // Redirect held under dmem_wait for four cycles.
    ex_redirect = 1; ex_redirect_pc = 64'h0000_2222; dmem_wait = 1;
    repeat (4) step();
    dmem_wait = 0;
    step();
    ex_redirect = 0;
    repeat (2) step();

    // Reset in the middle of DRAIN.
    ifetch_req = 1; ex_redirect = 1; ex_redirect_pc = 64'h0000_3333;
    step();
    ex_redirect = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    #1 check("rst_drain", 64'({drop_iresp, busy}), 64'b00);
    step();
    clear_inputs();
    step();
    check_perf();

    // Random traffic; redirects are offered only while none is pending.
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 99) < 2);
      ifetch_req     = ($urandom_range(0, 9) < 6);
      iresp_data_ok  = ($urandom_range(0, 9) < 4);
      dmem_wait      = ($urandom_range(0, 9) < 1);
      exe_busy       = ($urandom_range(0, 9) < 1);
      id_rs1         = REG_W'($urandom_range(0, 3));
      id_rs2         = REG_W'($urandom_range(0, 3));
      ex_rd          = REG_W'($urandom_range(0, 3));
      id_use_rs1     = 1'($urandom);
      id_use_rs2     = 1'($urandom);
      ex_is_load     = 1'($urandom);
      ex_redirect    = !m_pending && ($urandom_range(0, 9) < 2);
      ex_redirect_pc = {32'($urandom), 32'($urandom)};
      step();
    end
    clear_inputs();
    step();
    check_perf();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
